// File: rtl/seg7_scan_ctrl_if.sv
// Bus bundle between a host and the 7-segment scan controller.
// Host side drives display data and control; controller side drives the
// digit strobes, decoder feed and debug view of its internal state.
//
// Handshake: 'load' is a single-cycle strobe with no back-pressure. The
// controller always accepts it, so there is no ready signal. 'frame_done' is
// a single-cycle pulse. It marks the edge where pending data became visible.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    enable;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    lz_suppress;

    logic [3:0]              seg_in;
    logic                    seg_enable;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic                    dp_out;
    logic                    frame_done;

    // Debug view of the controller FSM and its pending buffer flag
    logic [1:0]              state_dbg;
    logic                    pend_valid_dbg;

    modport master (
        output enable, load, digits_in, dp_in, lz_suppress,
        input  seg_in, seg_enable, digit_sel, dp_out, frame_done,
        input  state_dbg, pend_valid_dbg
    );

    modport slave (
        input  enable, load, digits_in, dp_in, lz_suppress,
        output seg_in, seg_enable, digit_sel, dp_out, frame_done,
        output state_dbg, pend_valid_dbg
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexing scan controller for a multi-digit common-anode
// 7-segment display. One nibble is presented per lit digit to a shared
// decoder. A blanking gap separates the digits. New data is double-buffered
// and becomes visible only at frame boundaries.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    seg7_scan_ctrl_if.slave   bus
);

    localparam int DW      = 4 * NUM_DIGITS;
    localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    // FSM state
    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    // Display buffers: 'act' is what is being scanned, 'pend' waits for a frame edge
    logic [DW-1:0]         act_q, act_d;
    logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
    logic [DW-1:0]         pend_q, pend_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_valid_q, pend_valid_d;

    // Registered outputs
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [3:0]            seg_in_q, seg_in_d;
    logic                  seg_en_q, seg_en_d;
    logic                  dp_out_q, dp_out_d;
    logic                  frame_done_q, frame_done_d;

    // Control strobes from the FSM
    logic                  commit;
    logic                  advance;

    // Leading-zero suppression flags for the data about to be shown
    logic [NUM_DIGITS-1:0] supp;
    logic                  zero_run;

    // Next-state logic: dwell counters, digit stepping and frame commit points
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        commit       = 1'b0;
        advance      = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.enable) begin
                    state_d = ST_SHOW;
                    idx_d   = '0;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end
            end
            ST_SHOW: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == SHOW_LAST) begin
                    cnt_d = '0;
                    if (BLANK_CYCLES > 0) begin
                        state_d = ST_BLANK;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_BLANK: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // Next-digit step; the last digit closes the frame and commits new data
        if (advance) begin
            state_d = ST_SHOW;
            if (idx_q == IDX_LAST) begin
                idx_d        = '0;
                frame_done_d = 1'b1;
                commit       = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    // Buffer update: a load on a commit edge goes straight to the active buffer
    always_comb begin
        act_d        = act_q;
        act_dp_d     = act_dp_q;
        pend_d       = pend_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;

        if (commit) begin
            if (bus.load) begin
                act_d        = bus.digits_in;
                act_dp_d     = bus.dp_in;
                pend_d       = bus.digits_in;
                pend_dp_d    = bus.dp_in;
                pend_valid_d = 1'b0;
            end else if (pend_valid_q) begin
                act_d        = pend_q;
                act_dp_d     = pend_dp_q;
                pend_valid_d = 1'b0;
            end
        end else if (bus.load) begin
            pend_d       = bus.digits_in;
            pend_dp_d    = bus.dp_in;
            pend_valid_d = 1'b1;
        end
    end

    // Digit i>0 is blanked when it and every more significant digit are zero
    always_comb begin
        supp     = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run & (act_d[4*i +: 4] == 4'h0);
            supp[i]  = bus.lz_suppress & zero_run;
        end
    end

    // Output decode from the upcoming state so outputs are registered with it
    always_comb begin
        sel_d    = '1;
        seg_in_d = seg_in_q;
        seg_en_d = 1'b0;
        dp_out_d = 1'b0;

        case (state_d)
            ST_IDLE: begin
                seg_in_d = '0;
            end
            ST_SHOW: begin
                sel_d = ~(NUM_DIGITS'(1) << idx_d);
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (idx_d == IW'(i)) begin
                        seg_in_d = act_d[4*i +: 4];
                        seg_en_d = ~supp[i];
                        dp_out_d = act_dp_d[i];
                    end
                end
            end
            default: begin
                // Blanking gap: all strobes off, decoder input frozen
            end
        endcase
    end

    // FSM state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Active and pending display buffers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_q        <= '0;
            act_dp_q     <= '0;
            pend_q       <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            act_q        <= act_d;
            act_dp_q     <= act_dp_d;
            pend_q       <= pend_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q        <= '1;
            seg_in_q     <= '0;
            seg_en_q     <= 1'b0;
            dp_out_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            seg_in_q     <= seg_in_d;
            seg_en_q     <= seg_en_d;
            dp_out_q     <= dp_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.digit_sel      = sel_q;
    assign bus.seg_in         = seg_in_q;
    assign bus.seg_enable     = seg_en_q;
    assign bus.dp_out         = dp_out_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.state_dbg      = state_q;
    assign bus.pend_valid_dbg = pend_valid_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl. A frame-level model predicts, for every
// cycle, which digit is lit and with what content. A monitor pops those
// predictions whenever a digit is lit or a frame_done pulse appears.
module tb_seg7_scan_ctrl;

    localparam int ND   = 4;
    localparam int RD   = 4;
    localparam int BC   = 2;
    localparam int SLOT = RD + BC;
    localparam int FP   = ND * SLOT;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus();

    seg7_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;

    // {cycle[31:0], digit_sel[3:0], seg_in[3:0], seg_enable, dp_out}
    logic [41:0] exp_q[$];
    int          fd_q[$];
    logic [41:0] mon_e;

    // Reference model of the display buffers
    logic [15:0] m_active, m_pend;
    logic [3:0]  m_active_dp, m_pend_dp;
    bit          m_pend_valid;

    // Per-frame load plan: offset 1..FP of the sampling edge within a frame, 0 = none
    int          ld_off_a[4], ld_off_b[4];
    logic [15:0] ld_dat_a[4], ld_dat_b[4];
    logic [3:0]  ld_dp_a[4],  ld_dp_b[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic clear_plan();
        for (int f = 0; f < 4; f++) begin
            ld_off_a[f] = 0;
            ld_off_b[f] = 0;
            ld_dat_a[f] = '0;
            ld_dat_b[f] = '0;
            ld_dp_a[f]  = '0;
            ld_dp_b[f]  = '0;
        end
    endtask

    // Expected lit cycles of one frame starting at 'start', up to offset max_off
    task automatic push_entries(input int start, input logic [15:0] d, input logic [3:0] dp,
                                input bit lz, input int max_off);
        int top;
        top = 0;
        for (int i = 0; i < ND; i++) begin
            if (d[4*i +: 4] != 4'h0) top = i;
        end
        for (int dg = 0; dg < ND; dg++) begin
            for (int c = 0; c < RD; c++) begin
                int         off;
                logic [3:0] sel;
                logic       en;
                off = dg * SLOT + c;
                sel = ~(4'b0001 << dg);
                en  = !lz || (dg <= top);
                if (off <= max_off)
                    exp_q.push_back({32'(start + off), sel, d[4*dg +: 4], en, dp[dg]});
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        while (exp_q.size() > 0 && int'(exp_q[0][41:10]) < cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL lit_missing: digit expected at cycle %0d got no match, now cycle %0d",
                     int'(mon_e[41:10]), cyc);
        end
        if (bus.digit_sel != 4'hF) begin
            if (exp_q.size() > 0 && int'(exp_q[0][41:10]) == cyc) begin
                mon_e = exp_q.pop_front();
                check("lit_outputs", {22'd0, bus.digit_sel, bus.seg_in, bus.seg_enable, bus.dp_out},
                      {22'd0, mon_e[9:0]});
            end else begin
                checks++;
                failures++;
                $display("FAIL unexpected_lit: got digit_sel %0h at cycle %0d expected all off",
                         bus.digit_sel, cyc);
            end
        end else begin
            check("dark_seg_enable", {31'd0, bus.seg_enable}, 32'd0);
            check("dark_dp_out", {31'd0, bus.dp_out}, 32'd0);
        end

        while (fd_q.size() > 0 && fd_q[0] < cyc) begin
            checks++;
            failures++;
            $display("FAIL frame_done_missing: got none expected pulse at cycle %0d", fd_q[0]);
            void'(fd_q.pop_front());
        end
        if (bus.frame_done) begin
            if (fd_q.size() > 0 && fd_q[0] == cyc) begin
                checks++;
                void'(fd_q.pop_front());
            end else begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame_done: got pulse at cycle %0d expected none", cyc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge while the scanner is idle
    task automatic load_now(input logic [15:0] d, input logic [3:0] dp);
        bus.load      = 1'b1;
        bus.digits_in = d;
        bus.dp_in     = dp;
        @(negedge clk);
        bus.load     = 1'b0;
        m_pend       = d;
        m_pend_dp    = dp;
        m_pend_valid = 1'b1;
        check("pend_valid_set", {31'd0, bus.pend_valid_dbg}, 32'd1);
    endtask

    // Run nframes full frames following the load plan, then 'partial' more
    // cycles into the next frame, then stop by enable=0 or by reset.
    task automatic scan(input int nframes, input int partial, input bit abort_reset,
                        input bit part_load, input bit lz);
        int          s;
        logic [15:0] cur, nxt;
        logic [3:0]  cur_dp, nxt_dp;
        bit          loaded_prev;

        bus.lz_suppress = lz;
        bus.enable      = 1'b1;
        s = cyc + 1;
        if (m_pend_valid) begin
            m_active     = m_pend;
            m_active_dp  = m_pend_dp;
            m_pend_valid = 1'b0;
        end
        cur         = m_active;
        cur_dp      = m_active_dp;
        loaded_prev = 1'b0;

        for (int f = 0; f < nframes; f++) begin
            push_entries(s + FP * f, cur, cur_dp, lz, FP - 1);
            fd_q.push_back(s + FP * (f + 1));
            nxt    = cur;
            nxt_dp = cur_dp;
            for (int o = 1; o <= FP; o++) begin
                @(negedge clk);
                if (o == 1)
                    check("pend_clear_at_frame_start", {31'd0, bus.pend_valid_dbg}, 32'd0);
                else if (loaded_prev)
                    check("pend_valid_after_load", {31'd0, bus.pend_valid_dbg}, 32'd1);
                bus.load    = 1'b0;
                loaded_prev = 1'b0;
                if (ld_off_a[f] == o) begin
                    bus.load      = 1'b1;
                    bus.digits_in = ld_dat_a[f];
                    bus.dp_in     = ld_dp_a[f];
                    nxt           = ld_dat_a[f];
                    nxt_dp        = ld_dp_a[f];
                    loaded_prev   = (o < FP);
                end
                if (ld_off_b[f] == o) begin
                    bus.load      = 1'b1;
                    bus.digits_in = ld_dat_b[f];
                    bus.dp_in     = ld_dp_b[f];
                    nxt           = ld_dat_b[f];
                    nxt_dp        = ld_dp_b[f];
                    loaded_prev   = (o < FP);
                end
            end
            cur    = nxt;
            cur_dp = nxt_dp;
        end

        m_active    = cur;
        m_active_dp = cur_dp;
        push_entries(s + FP * nframes, cur, cur_dp, lz, partial);
        @(negedge clk);
        bus.load = 1'b0;
        check("pend_clear_at_frame_start", {31'd0, bus.pend_valid_dbg}, 32'd0);

        for (int q = 0; q < partial; q++) begin
            if (q == 0 && part_load) begin
                bus.load      = 1'b1;
                bus.digits_in = 16'($urandom);
                bus.dp_in     = 4'($urandom_range(0, 15));
                m_pend        = bus.digits_in;
                m_pend_dp     = bus.dp_in;
                m_pend_valid  = 1'b1;
            end
            @(negedge clk);
            bus.load = 1'b0;
        end

        if (abort_reset) begin
            #1 reset = 1'b1;
            bus.enable   = 1'b0;
            m_active     = '0;
            m_active_dp  = '0;
            m_pend       = '0;
            m_pend_dp    = '0;
            m_pend_valid = 1'b0;
            @(negedge clk);
            check("reset_digit_sel", {28'd0, bus.digit_sel}, 32'hF);
            check("reset_seg_in", {28'd0, bus.seg_in}, 32'd0);
            check("reset_pend_valid", {31'd0, bus.pend_valid_dbg}, 32'd0);
            reset = 1'b0;
        end else begin
            bus.enable = 1'b0;
            @(negedge clk);
            check("abort_digit_sel", {28'd0, bus.digit_sel}, 32'hF);
            check("idle_seg_in", {28'd0, bus.seg_in}, 32'd0);
            check("pend_kept", {31'd0, bus.pend_valid_dbg}, {31'd0, m_pend_valid});
        end
        clear_plan();
        repeat (2) @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int          n;
        logic [15:0] rd;

        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.load        = 1'b0;
        bus.digits_in   = '0;
        bus.dp_in       = '0;
        bus.lz_suppress = 1'b0;
        m_active        = '0;
        m_active_dp     = '0;
        m_pend          = '0;
        m_pend_dp       = '0;
        m_pend_valid    = 1'b0;
        clear_plan();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // T1: reset values and a dark idle display
        check("rst_digit_sel", {28'd0, bus.digit_sel}, 32'hF);
        check("rst_seg_in", {28'd0, bus.seg_in}, 32'd0);
        check("rst_seg_enable", {31'd0, bus.seg_enable}, 32'd0);
        check("rst_dp_out", {31'd0, bus.dp_out}, 32'd0);
        check("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
        check("rst_pend_valid", {31'd0, bus.pend_valid_dbg}, 32'd0);
        repeat (20) @(negedge clk);

        // T2: scan order and frame period
        load_now(16'h4321, 4'b0101);
        scan(2, 0, 1'b0, 1'b0, 1'b0);

        // T3: load while digit 1 is lit; visible only from the next frame
        ld_off_a[0] = 8;  ld_dat_a[0] = 16'h8765; ld_dp_a[0] = 4'b1000;
        scan(2, 0, 1'b0, 1'b0, 1'b0);

        // T4: load exactly on the frame_done edge bypasses pending
        ld_off_a[0] = FP; ld_dat_a[0] = 16'hABCD; ld_dp_a[0] = 4'b0010;
        scan(2, 0, 1'b0, 1'b0, 1'b0);

        // T5: leading-zero suppression
        load_now(16'h0070, 4'b0000);
        scan(1, 0, 1'b0, 1'b0, 1'b1);
        load_now(16'h0000, 4'b1100);
        scan(1, 0, 1'b0, 1'b0, 1'b1);

        // T6: stop mid-BLANK with a pending load kept, restart, then reset mid-SHOW
        load_now(16'h1357, 4'b0001);
        scan(0, 5, 1'b0, 1'b1, 1'b0);
        scan(1, 0, 1'b0, 1'b0, 1'b0);
        scan(1, 13, 1'b1, 1'b0, 1'b0);
        load_now(16'h2468, 4'b1111);
        scan(1, 0, 1'b0, 1'b0, 1'b0);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                rd = 16'($urandom) >> (4 * $urandom_range(0, 3));
                load_now(rd, 4'($urandom_range(0, 15)));
            end
            n = $urandom_range(1, 3);
            for (int f = 0; f < n; f++) begin
                ld_off_a[f] = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, FP);
                ld_off_b[f] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, FP) : 0;
                ld_dat_a[f] = 16'($urandom) >> (4 * $urandom_range(0, 3));
                ld_dat_b[f] = 16'($urandom) >> (4 * $urandom_range(0, 3));
                ld_dp_a[f]  = 4'($urandom_range(0, 15));
                ld_dp_b[f]  = 4'($urandom_range(0, 15));
            end
            scan(n, $urandom_range(0, FP - 1), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("fd_q_drained", 32'(fd_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
